// File: rtl/eth_tx_pkg.sv
// Shared types and frame-size constants for the Ethernet TX scheduler.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents: frame kind encoding, scheduler state encoding, protocol header
// sizes and the frame length helpers used when a source is granted.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        KIND_NONE      = 2'b00,
        KIND_HOST_ARP  = 2'b01,
        KIND_UDP       = 2'b10,
        KIND_ARP_REPLY = 2'b11
    } tx_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_e;

    localparam logic [15:0] ETH_HDR_LEN     = 16'd14;
    localparam logic [15:0] IPV4_HDR_LEN    = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
    localparam logic [15:0] ARP_PAYLOAD_LEN = 16'd28;
    localparam logic [15:0] MIN_FRAME_LEN   = 16'd60;
    localparam logic [15:0] MAX_UDP_PAYLOAD = 16'd1472;

    // Bytes in front of the UDP payload (Ethernet + IPv4 + UDP headers).
    localparam logic [15:0] UDP_OVERHEAD = ETH_HDR_LEN + IPV4_HDR_LEN + UDP_HDR_LEN;

    // An ARP frame is 42 bytes of headers, always padded up to the minimum.
    localparam logic [15:0] ARP_RAW_LEN   = ETH_HDR_LEN + ARP_PAYLOAD_LEN;
    localparam logic [15:0] ARP_FRAME_LEN = (ARP_RAW_LEN < MIN_FRAME_LEN) ? MIN_FRAME_LEN
                                                                          : ARP_RAW_LEN;

    // UDP frame length excluding FCS, padded to the minimum frame size.
    // Callers only pass payloads up to MAX_UDP_PAYLOAD, so the sum cannot wrap.
    function automatic logic [15:0] udp_frame_len(input logic [15:0] payload_len);
        logic [15:0] raw;
        raw = payload_len + UDP_OVERHEAD;
        return (raw < MIN_FRAME_LEN) ? MIN_FRAME_LEN : raw;
    endfunction

endpackage

// File: rtl/tx_packet_sched_if.sv
// Scheduler <-> frame builder handshake bundle.
// Latency: n/a (wires only).
// Backpressure: o_tx_req is held until the builder raises i_tx_ack.
//
// Signals: o_tx_req/o_tx_kind/o_tx_len driven by the scheduler (master),
// i_tx_ack/i_tx_done driven by the frame builder (slave).
interface tx_packet_sched_if;
    import eth_tx_pkg::*;

    logic        o_tx_req;
    tx_kind_e    o_tx_kind;
    logic [15:0] o_tx_len;
    logic        i_tx_ack;
    logic        i_tx_done;

    modport master (
        output o_tx_req,
        output o_tx_kind,
        output o_tx_len,
        input  i_tx_ack,
        input  i_tx_done
    );

    modport slave (
        input  o_tx_req,
        input  o_tx_kind,
        input  o_tx_len,
        output i_tx_ack,
        output i_tx_done
    );
endinterface

// File: rtl/sched_down_counter.sv
// Loadable down-counter with zero flag, shared by the frame timeout and the IFG.
// Latency: load/decrement take effect at the next clk edge; zero is combinational.
// Backpressure: none; load has priority over dec, and the count saturates at 0.
//
// Ports: clk, rst (sync, active-high), load + load_val, dec, zero (count == 0).
module sched_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/tx_packet_sched.sv
// Fixed-priority TX frame scheduler: ARP reply > host ARP > UDP, one frame at a time.
// Latency: source pulse -> o_tx_req is 2 cycles when idle; done -> next req is IFG+1 edges.
// Backpressure: o_tx_req held until i_tx_ack; requests arriving while busy stay pending.
//
// Ports: clk, rst (sync, active-high); i_send_packet (1 ARP, 2 UDP), i_arp_reply_req,
// i_udp_data_ready/i_udp_data_len from the payload buffer; tx (master) to the frame
// builder; o_busy, o_timeout/o_len_err pulses, o_pending = {udp, host_arp, arp_reply}.
module tx_packet_sched
    import eth_tx_pkg::*;
#(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_send_packet,
    input  logic                     i_arp_reply_req,
    input  logic                     i_udp_data_ready,
    input  logic [15:0]              i_udp_data_len,
    tx_packet_sched_if.master        tx,
    output logic                     o_busy,
    output logic                     o_timeout,
    output logic                     o_len_err,
    output logic [2:0]               o_pending
);
    localparam int IFG_EFF = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int TMO_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int CNT_MAX = (TMO_EFF > IFG_EFF) ? TMO_EFF : IFG_EFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The counter is loaded with N-1 so that zero marks the N-th cycle of the
    // window; the state then leaves on that cycle's closing edge.
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_EFF - 1);
    localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_EFF - 1);

    sched_state_e state;
    logic [2:0]   pend;
    logic [2:0]   pend_set;
    logic [2:0]   pend_clr;
    tx_kind_e     grant_kind;
    logic [15:0]  grant_len;
    logic         udp_reject;
    logic         go_req;
    logic         ack_hit;
    logic         done_hit;
    logic         timer_exp;
    logic         go_gap;
    logic         ctr_load;
    logic         ctr_dec;
    logic         ctr_zero;
    logic [CNT_W-1:0] ctr_val;

    assign pend_set  = {(i_send_packet == 2'd2), (i_send_packet == 2'd1), i_arp_reply_req};
    assign o_pending = pend;

    // Grant selection from the registered flags, only while idle. A UDP grant
    // with an oversized payload still consumes the flag but issues no frame.
    always_comb begin
        grant_kind = KIND_NONE;
        grant_len  = '0;
        pend_clr   = '0;
        udp_reject = 1'b0;
        if (state == ST_IDLE) begin
            if (pend[0]) begin
                grant_kind = KIND_ARP_REPLY;
                grant_len  = ARP_FRAME_LEN;
                pend_clr   = 3'b001;
            end else if (pend[1]) begin
                grant_kind = KIND_HOST_ARP;
                grant_len  = ARP_FRAME_LEN;
                pend_clr   = 3'b010;
            end else if (pend[2] && i_udp_data_ready) begin
                pend_clr = 3'b100;
                if (i_udp_data_len > MAX_UDP_PAYLOAD) begin
                    udp_reject = 1'b1;
                end else begin
                    grant_kind = KIND_UDP;
                    grant_len  = udp_frame_len(i_udp_data_len);
                end
            end
        end
    end

    assign go_req    = (grant_kind != KIND_NONE);
    assign ack_hit   = (state == ST_REQ) && tx.i_tx_ack;
    assign done_hit  = (state == ST_WAIT_DONE) && tx.i_tx_done;
    assign timer_exp = ((state == ST_REQ) || (state == ST_WAIT_DONE)) && ctr_zero;
    // Done beats a simultaneous expiry; an ack in the expiry cycle still counts.
    assign go_gap    = ((state == ST_WAIT_DONE) && (done_hit || timer_exp)) ||
                       ((state == ST_REQ) && !ack_hit && timer_exp);

    assign ctr_load = go_req || go_gap;
    assign ctr_val  = go_req ? TMO_LOAD : IFG_LOAD;
    assign ctr_dec  = (state != ST_IDLE);

    sched_down_counter #(
        .WIDTH (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pend         <= '0;
            tx.o_tx_req  <= 1'b0;
            tx.o_tx_kind <= KIND_NONE;
            tx.o_tx_len  <= '0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            // Set wins over the grant clear, so a re-request in the grant cycle survives.
            pend      <= (pend & ~pend_clr) | pend_set;
            o_timeout <= 1'b0;
            o_len_err <= udp_reject;
            case (state)
                ST_IDLE: begin
                    if (go_req) begin
                        state        <= ST_REQ;
                        tx.o_tx_req  <= 1'b1;
                        tx.o_tx_kind <= grant_kind;
                        tx.o_tx_len  <= grant_len;
                        o_busy       <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_hit) begin
                        state       <= ST_WAIT_DONE;
                        tx.o_tx_req <= 1'b0;
                    end else if (timer_exp) begin
                        state       <= ST_GAP;
                        tx.o_tx_req <= 1'b0;
                        o_timeout   <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_hit) begin
                        state <= ST_GAP;
                    end else if (timer_exp) begin
                        state     <= ST_GAP;
                        o_timeout <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (ctr_zero) begin
                        state        <= ST_IDLE;
                        tx.o_tx_kind <= KIND_NONE;
                        tx.o_tx_len  <= '0;
                        o_busy       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
